// File: rtl/uart_rx_fifo_if.sv
// Receive-side handshake bundle of uart_rx_fifo.
// The receiver drives the FIFO head; the consumer drives rx_ready.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_BITS-1:0]        rx_data;
    logic                        rx_perr;
    logic                        rx_ferr;
    logic                        rx_valid;
    logic                        rx_ready;
    logic [$clog2(FIFO_DEPTH):0] rx_count;

    modport master (
        output rx_data, rx_perr, rx_ferr, rx_valid, rx_count,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_perr, rx_ferr, rx_valid, rx_count,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, majority vote, optional parity,
// 1/2 stop bits, first-word-fall-through receive FIFO with overrun flag.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic enable,
    output logic overrun,
    input  logic clear_err,
    uart_rx_fifo_if.master bus
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = DATA_BITS + 2;
    localparam logic [3:0] LASTD = 4'(DATA_BITS - 1);
    localparam logic [3:0] LASTS = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic                 sync1, rxs;
    logic [PW-1:0]        presc, presc_n;
    logic [3:0]           idx, idx_n;
    logic [3:0]           bitcnt, bit_n;
    logic                 s7, s7_n, s8, s8_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 perr, perr_n, ferr, ferr_n;
    logic                 push;
    logic [EW-1:0]        wdata;
    logic                 tick, dec, last, maj, exp_par;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr, count;
    logic          full, pop, wr;

    assign tick    = presc == PW'(DIV - 1);
    assign dec     = idx == 4'd9;
    assign last    = idx == 4'd15;
    assign maj     = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
    assign exp_par = (PARITY == 1) ? ~^sh : ^sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            rxs    <= 1'b1;
            state  <= IDLE;
            presc  <= '0;
            idx    <= '0;
            bitcnt <= '0;
            s7     <= 1'b1;
            s8     <= 1'b1;
            sh     <= '0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            sync1  <= rx;
            rxs    <= sync1;
            state  <= state_n;
            presc  <= presc_n;
            idx    <= idx_n;
            bitcnt <= bit_n;
            s7     <= s7_n;
            s8     <= s8_n;
            sh     <= sh_n;
            perr   <= perr_n;
            ferr   <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        idx_n   = idx;
        bit_n   = bitcnt;
        s7_n    = s7;
        s8_n    = s8;
        sh_n    = sh;
        perr_n  = perr;
        ferr_n  = ferr;
        push    = 1'b0;
        wdata   = {perr, ferr, sh};
        if (state == IDLE) begin
            presc_n = '0;
            idx_n   = '0;
            if (enable && !rxs) begin
                state_n = START;
                bit_n   = '0;
                perr_n  = 1'b0;
                ferr_n  = 1'b0;
            end
        end else if (!enable) begin
            state_n = IDLE;
            presc_n = '0;
            idx_n   = '0;
        end else if (tick) begin
            presc_n = '0;
            idx_n   = idx + 4'd1;
            if (idx == 4'd7) s7_n = rxs;
            if (idx == 4'd8) s8_n = rxs;
            unique case (state)
                START: begin
                    if (dec && maj) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end else if (last) begin
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (dec) sh_n = {maj, sh[DATA_BITS-1:1]};
                    if (last) begin
                        if (bitcnt == LASTD) begin
                            bit_n   = '0;
                            state_n = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_n = bitcnt + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (dec) perr_n = maj != exp_par;
                    if (last) begin
                        bit_n   = '0;
                        state_n = STOP;
                    end
                end
                STOP: begin
                    if (dec) begin
                        if (!maj) ferr_n = 1'b1;
                        // Leave right at the decision so a new start bit is not missed
                        if (bitcnt == LASTS) begin
                            push    = 1'b1;
                            wdata   = {perr, ferr_n, sh};
                            state_n = IDLE;
                            idx_n   = '0;
                        end
                    end else if (last) begin
                        bit_n = bitcnt + 4'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else begin
            presc_n = presc + 1'b1;
        end
    end

    assign count = wptr - rptr;
    assign full  = count == (AW+1)'(FIFO_DEPTH);
    assign pop   = bus.rx_valid & bus.rx_ready;
    assign wr    = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && full && !pop) overrun <= 1'b1;
            else if (clear_err)       overrun <= 1'b0;
        end
    end

    assign {bus.rx_perr, bus.rx_ferr, bus.rx_data} = mem[rptr[AW-1:0]];
    assign bus.rx_valid = count != '0;
    assign bus.rx_count = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 and 8E1 instances, DIV=1,
// 4-entry FIFO, vector table plus hand-written corner sequences.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_n = 1'b1;
    logic rx_e = 1'b1;
    logic enable = 1'b1;
    logic clear_err = 1'b0;
    logic ovr_n, ovr_e;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifn ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ife ();

    uart_rx_fifo #(
        .CLK_FREQ(1843200), .BAUD_RATE(115200), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_n (
        .clk(clk), .reset(reset), .rx(rx_n), .enable(enable),
        .overrun(ovr_n), .clear_err(clear_err), .bus(ifn)
    );

    uart_rx_fifo #(
        .CLK_FREQ(1843200), .BAUD_RATE(115200), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_e (
        .clk(clk), .reset(reset), .rx(rx_e), .enable(enable),
        .overrun(ovr_e), .clear_err(clear_err), .bus(ife)
    );

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       usep;
        logic       pb;
        logic       sb;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t vt [9];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(int sel, logic b);
        if (sel == 0) rx_n = b;
        else rx_e = b;
    endtask

    task automatic send(int sel, logic [15:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            drv(sel, bits[i]);
            tick(16);
        end
        drv(sel, 1'b1);
    endtask

    function automatic logic [15:0] frm(logic [7:0] d, logic usep,
                                        logic pb, logic sb);
        if (usep) return {5'b0, sb, pb, d, 1'b0};
        return {6'b0, sb, d, 1'b0};
    endfunction

    task automatic pop(int sel);
        if (sel == 0) ifn.rx_ready = 1'b1;
        else ife.rx_ready = 1'b1;
        tick(1);
        ifn.rx_ready = 1'b0;
        ife.rx_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int nerr;
        logic [7:0] got [$];
        logic [7:0] d;
        logic v, p, f;
        logic [15:0] bits;

        vt = '{
            '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0},
            '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0},
            '{0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1},
            '{0, 8'h96, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0},
            '{1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0},
            '{1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0},
            '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0},
            '{1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0},
            '{1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1}
        };
        ifn.rx_ready = 1'b0;
        ife.rx_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_valid", 32'(ifn.rx_valid), 0);
        chk("rst_count", 32'(ifn.rx_count), 0);
        chk("rst_overrun", 32'(ovr_n), 0);
        chk("rst_data", 32'(ifn.rx_data), 0);

        // back-to-back 8N1 with a consumer that is always ready
        lat = -1;
        nerr = 0;
        ifn.rx_ready = 1'b1;
        fork
            begin
                send(0, frm(8'hA5, 1'b0, 1'b0, 1'b1), 10);
                send(0, frm(8'h3C, 1'b0, 1'b0, 1'b1), 10);
            end
            for (int n = 1; n <= 400; n++) begin
                @(posedge clk);
                #1;
                if (ifn.rx_valid) begin
                    if (lat < 0) lat = n;
                    got.push_back(ifn.rx_data);
                    if (ifn.rx_perr || ifn.rx_ferr) nerr++;
                end
            end
        join
        ifn.rx_ready = 1'b0;
        chk("b2b_pops", 32'(got.size()), 2);
        chk("b2b_d0", got.size() > 0 ? 32'(got[0]) : 32'hFFFF, 32'hA5);
        chk("b2b_d1", got.size() > 1 ? 32'(got[1]) : 32'hFFFF, 32'h3C);
        chk("b2b_flags", 32'(nerr), 0);
        chk("b2b_latency", 32'(lat), 32'd155 + ((lat >= 153 && lat <= 157) ? 32'(lat - 155) : 32'd1000));

        for (int i = 0; i < 9; i++) begin
            send(vt[i].sel, frm(vt[i].d, vt[i].usep, vt[i].pb, vt[i].sb),
                 vt[i].usep ? 11 : 10);
            tick(20);
            if (vt[i].sel == 0) begin
                v = ifn.rx_valid; d = ifn.rx_data;
                p = ifn.rx_perr;  f = ifn.rx_ferr;
            end else begin
                v = ife.rx_valid; d = ife.rx_data;
                p = ife.rx_perr;  f = ife.rx_ferr;
            end
            chk($sformatf("v%0d_valid", i), 32'(v), 1);
            chk($sformatf("v%0d_data", i), 32'(d), 32'(vt[i].ed));
            chk($sformatf("v%0d_perr", i), 32'(p), 32'(vt[i].ep));
            chk($sformatf("v%0d_ferr", i), 32'(f), 32'(vt[i].ef));
            pop(vt[i].sel);
            chk($sformatf("v%0d_count", i),
                32'(vt[i].sel == 0 ? ifn.rx_count : ife.rx_count), 0);
        end

        // short low pulse: false start
        drv(0, 1'b0);
        tick(5);
        drv(0, 1'b1);
        tick(40);
        chk("glitch_count", 32'(ifn.rx_count), 0);
        chk("glitch_valid", 32'(ifn.rx_valid), 0);

        // one-clock low glitch at tick 8 of data bit 0 of 0xFF
        drv(0, 1'b0);
        tick(16);
        drv(0, 1'b1);
        tick(9);
        drv(0, 1'b0);
        tick(1);
        drv(0, 1'b1);
        tick(6 + 16 * 8 + 20);
        chk("bitglitch_valid", 32'(ifn.rx_valid), 1);
        chk("bitglitch_data", 32'(ifn.rx_data), 32'hFF);
        pop(0);

        // disabled receiver ignores a whole frame
        enable = 1'b0;
        send(0, frm(8'h00, 1'b0, 1'b0, 1'b1), 10);
        tick(20);
        enable = 1'b1;
        tick(20);
        chk("dis_idle_count", 32'(ifn.rx_count), 0);

        // enable dropped mid-frame, then a clean frame
        fork
            send(0, frm(8'hF0, 1'b0, 1'b0, 1'b1), 10);
            begin
                tick(90);
                enable = 1'b0;
            end
        join
        tick(20);
        enable = 1'b1;
        tick(20);
        chk("abort_count", 32'(ifn.rx_count), 0);
        send(0, frm(8'h5A, 1'b0, 1'b0, 1'b1), 10);
        tick(20);
        chk("after_abort_valid", 32'(ifn.rx_valid), 1);
        chk("after_abort_data", 32'(ifn.rx_data), 32'h5A);
        pop(0);

        // overrun with consumer stalled
        for (int k = 1; k <= 5; k++) begin
            send(0, frm(8'(k), 1'b0, 1'b0, 1'b1), 10);
            tick(20);
            if (k == 4) begin
                chk("full_count", 32'(ifn.rx_count), 4);
                chk("full_no_ovr", 32'(ovr_n), 0);
            end
        end
        chk("ovr_count", 32'(ifn.rx_count), 4);
        chk("ovr_flag", 32'(ovr_n), 1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovr_pop%0d", k), 32'(ifn.rx_data), 32'(k));
            pop(0);
        end
        chk("ovr_empty", 32'(ifn.rx_valid), 0);
        chk("ovr_sticky", 32'(ovr_n), 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("ovr_cleared", 32'(ovr_n), 0);

        // reset during data bit 3 with one entry already queued
        send(0, frm(8'h11, 1'b0, 1'b0, 1'b1), 10);
        tick(20);
        chk("prerst_count", 32'(ifn.rx_count), 1);
        bits = frm(8'h22, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drv(0, bits[i]);
            tick(16);
        end
        drv(0, bits[4]);
        tick(8);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        drv(0, 1'b1);
        chk("midrst_valid", 32'(ifn.rx_valid), 0);
        chk("midrst_count", 32'(ifn.rx_count), 0);
        chk("midrst_data", 32'(ifn.rx_data), 0);
        chk("midrst_flags", 32'({ifn.rx_perr, ifn.rx_ferr}), 0);
        tick(200);
        chk("midrst_nopush", 32'(ifn.rx_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
